image_blit_gu: RTL and testbench
================================

IMAGE_BLIT_GU -- requirements
Module: image_blit_gu

Interface
REQ-001 Parameter IMG_W, default 240: image width in pixels, range 1..511.
REQ-002 Parameter IMG_H, default 180: image height in pixels, range 1..255.
REQ-003 Parameter FRAMES, default 1: number of IMG_W x IMG_H frames stored back-to-back in ROM, range 1..16.
REQ-004 Parameter COLOUR_W, default 3: pixel colour width.
REQ-005 Derived ADDR_W = clog2(FRAMES*IMG_W*IMG_H); FSEL_W = max(1, clog2(FRAMES)).
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 plot  in  1  start request, sampled only in IDLE.
REQ-009 mode  in  1  0 = image copy from ROM, 1 = solid fill with fill_colour; latched at start.
REQ-010 frame_sel  in  FSEL_W  frame index, latched at start.
REQ-011 x_origin / y_origin  in  9 / 8  screen position of the top-left pixel, latched at start.
REQ-012 fill_colour  in  COLOUR_W  colour for mode 1, latched at start.
REQ-013 rom_addr  out  ADDR_W  ROM read address; ROM read latency is exactly 1 clk.
REQ-014 rom_data  in  COLOUR_W  ROM read data for the address of the previous cycle.
REQ-015 x_out / y_out / colour_out  out  9 / 8 / COLOUR_W  pixel write to VGA adapter.
REQ-016 writeEn  out  1  pixel write strobe, qualifying x_out/y_out/colour_out in the same cycle.
REQ-017 busy  out  1  high from the cycle after accepted start until done.
REQ-018 done  out  1  one-cycle pulse after the last pixel of a blit.

Function
REQ-019 States: IDLE, DRAW, FLUSH, DONE; IDLE->DRAW on plot=1; DRAW->FLUSH after pixel (IMG_W-1, IMG_H-1) is issued; FLUSH->DONE after 1 cycle; DONE->IDLE unconditionally.
REQ-020 Accepting plot latches mode, frame_sel, x/y origin and fill_colour; later changes to those inputs do not affect the blit in progress.
REQ-021 plot while not in IDLE is ignored, and no request is queued.
REQ-022 In DRAW, the x counter runs 0..IMG_W-1 and then wraps to 0 while the y counter increments; exactly IMG_W*IMG_H pixels are issued, one per clk, in raster order.
REQ-023 rom_addr = frame*IMG_W*IMG_H + y*IMG_W + x, computed at ADDR_W width with no truncation.
REQ-024 Pixel issued in cycle n appears on x_out/y_out/colour_out/writeEn in cycle n+1, so pipeline latency is 1 clk in both modes.
REQ-025 x_out = (x_origin + x) mod 512 and y_out = (y_origin + y) mod 256; overflow wraps silently.
REQ-026 mode 1 drives colour_out = fill_colour and holds rom_addr at 0.
REQ-027 writeEn is 0 in IDLE and DONE; done is high only in DONE; total latency from plot to done is IMG_W*IMG_H + 2 clk.
REQ-028 A frame_sel value >= FRAMES is clamped to FRAMES-1.

Reset
REQ-029 reset forces IDLE and zeroes the counters, latched registers, rom_addr, x_out, y_out, colour_out, writeEn, busy and done.
REQ-030 reset asserted mid-blit aborts immediately; no done is issued, and the first clk after reset release is IDLE.

Configuration
REQ-031 With macro IMAGE_BLIT_TRANSPARENCY_EN defined, parameter TRANSP_COLOUR (default 0) applies in mode 0: a pixel whose rom_data equals TRANSP_COLOUR has writeEn forced to 0, and timing and done are unchanged.
REQ-032 Without the macro, every pixel is written and TRANSP_COLOUR does not exist.

Structure
REQ-033 Package blit_pkg holds the state enum, the screen width constants SCREEN_X_W=9 and SCREEN_Y_W=8, and the clog2 helper.
REQ-034 Sub-module blit_raster_counter, with parameters IMG_W and IMG_H, provides the x/y counters and a last flag; the FSM and pixel pipeline stay in image_blit_gu.

Verification
REQ-035 IMG_W=4, IMG_H=3, origin (10,20), mode 0, plot pulse -> 12 writes covering x 10..13 and y 20..22 in raster order; done 14 clk after plot; colours match the ROM model.
REQ-036 FRAMES=4, frame_sel=2, IMG_W=4, IMG_H=3 -> first rom_addr 24, last rom_addr 35.
REQ-037 origin (510,254), IMG_W=4, IMG_H=3 -> x_out sequence 510,511,0,1 and y_out sequence 254,255,0.
REQ-038 mode 1 with fill_colour=3'b101 -> all 12 writes carry colour 101; plot re-pulsed mid-blit -> still exactly 12 writes and one done.
REQ-039 reset asserted after 5 writes -> all outputs 0 on the next cycle and no done; a fresh plot after release completes normally.
REQ-040 With IMAGE_BLIT_TRANSPARENCY_EN and TRANSP_COLOUR=0, a ROM holding 0 at addresses 1 and 5 -> 10 writes, with done timing identical to REQ-035.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared types and constants for the image blitter.
package blit_pkg;

   localparam int unsigned SCREEN_X_W = 9;
   localparam int unsigned SCREEN_Y_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StDraw,
      StFlush,
      StDone
   } blit_state_e;

   // Ceiling log2, evaluated at elaboration time for derived widths
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/blit_raster_counter.sv
// Raster-order x/y counter over an IMG_W x IMG_H image; wraps to (0,0) after the last pixel.
module blit_raster_counter
   import blit_pkg::*;
#(
   parameter int unsigned IMG_W = 240,
   parameter int unsigned IMG_H = 180
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  en_i,
   output logic [SCREEN_X_W-1:0] x_o,
   output logic [SCREEN_Y_W-1:0] y_o,
   output logic                  last_o
);

   logic [SCREEN_X_W-1:0] x_q, x_d;
   logic [SCREEN_Y_W-1:0] y_q, y_d;
   logic                  x_end, y_end;

   assign x_end  = (x_q == SCREEN_X_W'(IMG_W - 1));
   assign y_end  = (y_q == SCREEN_Y_W'(IMG_H - 1));
   assign last_o = x_end && y_end;
   assign x_o    = x_q;
   assign y_o    = y_q;

   // Next-state: advance x, carry into y at end of line, wrap both after the last pixel
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (en_i) begin
         if (x_end) begin
            x_d = '0;
            y_d = y_end ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // Counter state
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/image_blit_gu.sv
// Image blitter: copies a ROM frame (mode 0) or fills a solid rectangle (mode 1) to a VGA adapter.
// Optional macro IMAGE_BLIT_TRANSPARENCY_EN skips writes of ROM pixels equal to TRANSP_COLOUR.
module image_blit_gu
   import blit_pkg::*;
#(
   parameter int unsigned IMG_W    = 240,
   parameter int unsigned IMG_H    = 180,
   parameter int unsigned FRAMES   = 1,
   parameter int unsigned COLOUR_W = 3,
`ifdef IMAGE_BLIT_TRANSPARENCY_EN
   parameter logic [COLOUR_W-1:0] TRANSP_COLOUR = '0,
`endif
   // Floored at 1 so a 1-pixel single-frame image still has a legal address port
   localparam int unsigned ADDR_W = (clog2(FRAMES * IMG_W * IMG_H) > 0) ?
                                    clog2(FRAMES * IMG_W * IMG_H) : 1,
   localparam int unsigned FSEL_W = (clog2(FRAMES) > 0) ? clog2(FRAMES) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  plot,
   input  logic                  mode,
   input  logic [FSEL_W-1:0]     frame_sel,
   input  logic [SCREEN_X_W-1:0] x_origin,
   input  logic [SCREEN_Y_W-1:0] y_origin,
   input  logic [COLOUR_W-1:0]   fill_colour,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [COLOUR_W-1:0]   rom_data,
   output logic [SCREEN_X_W-1:0] x_out,
   output logic [SCREEN_Y_W-1:0] y_out,
   output logic [COLOUR_W-1:0]   colour_out,
   output logic                  writeEn,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned FRAME_PIX = IMG_W * IMG_H;

   blit_state_e           state_q;
   logic                  mode_q;
   logic [FSEL_W-1:0]     frame_q;
   logic [SCREEN_X_W-1:0] x_org_q;
   logic [SCREEN_Y_W-1:0] y_org_q;
   logic [COLOUR_W-1:0]   fill_q;
   logic                  busy_q, done_q;

   logic [SCREEN_X_W-1:0] x_out_q;
   logic [SCREEN_Y_W-1:0] y_out_q;
   logic                  valid_q;

   logic [SCREEN_X_W-1:0] cnt_x;
   logic [SCREEN_Y_W-1:0] cnt_y;
   logic                  cnt_last;
   logic                  drawing;
   logic [FSEL_W-1:0]     frame_clamped;

   assign drawing = (state_q == StDraw);

   blit_raster_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_raster (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (drawing),
      .x_o     (cnt_x),
      .y_o     (cnt_y),
      .last_o  (cnt_last)
   );

   // Out-of-range frame requests fall back to the last stored frame
   always_comb begin
      frame_clamped = frame_sel;
      if (32'(frame_sel) >= FRAMES) frame_clamped = FSEL_W'(FRAMES - 1);
   end

   // Control FSM with registered busy/done and start-time latching of request fields
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         mode_q  <= 1'b0;
         frame_q <= '0;
         x_org_q <= '0;
         y_org_q <= '0;
         fill_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (plot) begin
                  state_q <= StDraw;
                  mode_q  <= mode;
                  frame_q <= frame_clamped;
                  x_org_q <= x_origin;
                  y_org_q <= y_origin;
                  fill_q  <= fill_colour;
                  busy_q  <= 1'b1;
               end
            end
            StDraw: begin
               if (cnt_last) state_q <= StFlush;
            end
            StFlush: begin
               state_q <= StDone;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // ROM address of the pixel issued this cycle; parked at 0 outside image-copy draws
   always_comb begin
      rom_addr = '0;
      if (drawing && !mode_q) begin
         rom_addr = ADDR_W'(frame_q) * ADDR_W'(FRAME_PIX)
                  + ADDR_W'(cnt_y) * ADDR_W'(IMG_W)
                  + ADDR_W'(cnt_x);
      end
   end

   // One-stage pixel pipeline aligning screen coordinates with the 1-cycle ROM read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         x_out_q <= '0;
         y_out_q <= '0;
      end else begin
         valid_q <= drawing;
         if (drawing) begin
            x_out_q <= x_org_q + cnt_x;
            y_out_q <= y_org_q + cnt_y;
         end
      end
   end

   // Output colour and write strobe; ROM data arrives this cycle so it is not re-registered
   always_comb begin
      colour_out = '0;
      if (valid_q) colour_out = mode_q ? fill_q : rom_data;
`ifdef IMAGE_BLIT_TRANSPARENCY_EN
      writeEn = valid_q && !(!mode_q && (rom_data == TRANSP_COLOUR));
`else
      writeEn = valid_q;
`endif
   end

   assign x_out = x_out_q;
   assign y_out = y_out_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_image_blit_gu.sv
// Directed self-checking bench for image_blit_gu (4x3 image, 3 frames, 3-bit colour).
module tb_image_blit_gu;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       plot = 1'b0;
   logic       mode = 1'b0;
   logic [1:0] frame_sel = '0;
   logic [8:0] x_origin = '0;
   logic [7:0] y_origin = '0;
   logic [2:0] fill_colour = '0;
   logic [5:0] rom_addr;
   logic [2:0] rom_data = '0;
   logic [8:0] x_out;
   logic [7:0] y_out;
   logic [2:0] colour_out;
   logic       writeEn, busy, done;

   int n_checks = 0;
   int n_fails  = 0;

   image_blit_gu #(
      .IMG_W    (4),
      .IMG_H    (3),
      .FRAMES   (3),
      .COLOUR_W (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .plot        (plot),
      .mode        (mode),
      .frame_sel   (frame_sel),
      .x_origin    (x_origin),
      .y_origin    (y_origin),
      .fill_colour (fill_colour),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .x_out       (x_out),
      .y_out       (y_out),
      .colour_out  (colour_out),
      .writeEn     (writeEn),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // ROM contents: zero only at addresses 1 and 5
   function automatic logic [2:0] rom_fn(input int a);
      if (a == 1 || a == 5) return 3'd0;
      return 3'((a % 7) + 1);
   endfunction

   // Synchronous ROM, one clock read latency
   always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One blit from plot pulse to idle; outputs sampled on falling edges, n = cycles after accept
   task automatic run_blit(input logic m, input int fs, input int xo, input int yo,
                           input logic [2:0] fc, input bit repulse);
      int   efs, base, p;
      logic exp_we;
      logic [2:0] ecol;
      efs  = (fs > 2) ? 2 : fs;
      base = efs * 12;
      @(negedge clk);
      mode = m; frame_sel = 2'(fs); x_origin = 9'(xo); y_origin = 8'(yo);
      fill_colour = fc; plot = 1'b1;
      @(negedge clk);
      // Scramble request fields: the blit in flight must ignore them
      plot = 1'b0; mode = ~m; frame_sel = 2'd1; x_origin = 9'd300; y_origin = 8'd100;
      fill_colour = ~fc;
      for (int n = 1; n <= 16; n++) begin
         if (n > 1) @(negedge clk);
         if (n == 1) begin
            check_eq("rom_addr_first", 32'(rom_addr), m ? 0 : base);
            check_eq("busy_start", 32'(busy), 1);
         end
         if (n == 12) check_eq("rom_addr_last", 32'(rom_addr), m ? 0 : base + 11);
         if (n == 13) check_eq("busy_flush", 32'(busy), 1);
         p = n - 2;
         exp_we = (n >= 2 && n <= 13);
`ifdef IMAGE_BLIT_TRANSPARENCY_EN
         if (exp_we && !m && rom_fn(base + p) == 3'd0) exp_we = 1'b0;
`endif
         check_eq($sformatf("writeEn_n%0d", n), 32'(writeEn), 32'(exp_we));
         if (writeEn && exp_we) begin
            ecol = m ? fc : rom_fn(base + p);
            check_eq($sformatf("x_out_p%0d", p), 32'(x_out), (xo + p % 4) % 512);
            check_eq($sformatf("y_out_p%0d", p), 32'(y_out), (yo + p / 4) % 256);
            check_eq($sformatf("colour_p%0d", p), 32'(colour_out), 32'(ecol));
         end
         check_eq($sformatf("done_n%0d", n), 32'(done), (n == 14) ? 1 : 0);
         plot = repulse && (n >= 4) && (n <= 6);
      end
      plot = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_rom_addr", 32'(rom_addr), 0);
      check_eq("rst_writeEn", 32'(writeEn), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      reset = 1'b0;

      run_blit(1'b0, 0, 10, 20, 3'd0, 1'b0);     // basic copy, frame 0
      run_blit(1'b0, 2, 0, 0, 3'd0, 1'b0);       // frame 2: addresses 24..35
      run_blit(1'b0, 3, 50, 60, 3'd0, 1'b0);     // frame 3 clamps to 2
      run_blit(1'b0, 0, 510, 254, 3'd0, 1'b0);   // screen wrap
      run_blit(1'b1, 1, 5, 5, 3'b101, 1'b1);     // fill with re-pulsed plot

      // Abort mid-blit after 5 writes
      @(negedge clk);
      mode = 1'b0; frame_sel = 2'd2; x_origin = 9'd0; y_origin = 8'd0; plot = 1'b1;
      @(negedge clk);
      plot = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("pre_abort_we", 32'(writeEn), 1);
      check_eq("pre_abort_x", 32'(x_out), 0);
      check_eq("pre_abort_y", 32'(y_out), 1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_rom_addr", 32'(rom_addr), 0);
      check_eq("abort_x_out", 32'(x_out), 0);
      check_eq("abort_y_out", 32'(y_out), 0);
      check_eq("abort_colour", 32'(colour_out), 0);
      check_eq("abort_writeEn", 32'(writeEn), 0);
      check_eq("abort_busy", 32'(busy), 0);
      check_eq("abort_done", 32'(done), 0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         check_eq($sformatf("post_abort_done_%0d", k), 32'(done), 0);
         check_eq($sformatf("post_abort_we_%0d", k), 32'(writeEn), 0);
      end
      check_eq("post_abort_busy", 32'(busy), 0);

      run_blit(1'b0, 1, 100, 200, 3'd0, 1'b0);   // fresh blit after abort

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
